// File: rtl/runner_physics_core.sv
// Tick-driven jump, collision, health and score engine for the runner game.
// Optional feature macro: PHYS_BONUS_EN (tile code 3 becomes a bonus tile).
module runner_physics_core #(
  parameter int TILE_W       = 2,
  parameter int MAP_TILES    = 8,
  parameter int JUMP_TICKS   = 3,
  parameter int LIVES        = 3,
  parameter int INVULN_TICKS = 4,
  parameter int SCORE_W      = 16,
  parameter int BONUS_PTS    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [TILE_W*MAP_TILES-1:0]  map_tiles,
  input  logic                         jump,
  input  logic                         restart,
  output logic                         is_dead,
  output logic                         airborne,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic [SCORE_W-1:0]           score,
  output logic                         hit_pulse,
  output logic                         score_pulse
);
  localparam int LW = $clog2(LIVES+1);
  localparam int AW = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;
  localparam int IW = (INVULN_TICKS > 1) ? $clog2(INVULN_TICKS) : 1;
  localparam logic [AW-1:0] AIR_INIT   = AW'(JUMP_TICKS - 1);
  localparam logic [IW-1:0] INV_INIT   = IW'((INVULN_TICKS > 0) ? INVULN_TICKS - 1 : 0);
  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);

  typedef enum logic {V_GROUND, V_AIR} vert_t;
  typedef enum logic [1:0] {H_ALIVE, H_INVULN, H_DEAD} health_t;

  vert_t                vert_q, vert_d;
  health_t              health_q, health_d;
  logic [AW-1:0]        air_cnt_q, air_cnt_d;
  logic [IW-1:0]        inv_cnt_q, inv_cnt_d;
  logic [LW-1:0]        lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 jump_prev_q, jump_prev_d;
  logic                 jump_req_q, jump_req_d;
  logic                 dead_q, dead_d;
  logic                 hit_q, hit_d;
  logic                 spulse_q, spulse_d;

  logic [TILE_W-1:0]    player_tile;
  logic                 req_now, air_now, is_low, is_high, is_bonus, hit_now, clear_now;
  logic                 unused_tiles;

  assign player_tile  = map_tiles[TILE_W*MAP_TILES-1 -: TILE_W];
  assign unused_tiles = ^map_tiles;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

`ifdef PHYS_BONUS_EN
  // A bonus worth more than the score range simply saturates the counter.
  localparam logic [SCORE_W-1:0] BONUS_INC =
    (SCORE_W < 31 && BONUS_PTS > (1 << SCORE_W) - 1) ? {SCORE_W{1'b1}} : SCORE_W'(BONUS_PTS);
  assign is_bonus = (player_tile == TILE_W'(3));
`else
  localparam logic [SCORE_W-1:0] BONUS_INC = '0;
  assign is_bonus = 1'b0;
`endif

  always_comb begin
    vert_d      = vert_q;
    health_d    = health_q;
    air_cnt_d   = air_cnt_q;
    inv_cnt_d   = inv_cnt_q;
    lives_d     = lives_q;
    score_d     = score_q;
    dead_d      = dead_q;
    hit_d       = 1'b0;
    spulse_d    = 1'b0;
    jump_prev_d = jump;
    req_now     = jump_req_q | (jump & ~jump_prev_q);
    // No queued jumps: a request made while in the air or dead is dropped.
    jump_req_d  = req_now & (vert_q == V_GROUND) & ~dead_q;
    air_now     = 1'b0;
    is_low      = (player_tile == TILE_W'(1));
    is_high     = (player_tile == TILE_W'(2));
    hit_now     = 1'b0;
    clear_now   = 1'b0;

    if (restart) begin
      vert_d      = V_GROUND;
      health_d    = H_ALIVE;
      air_cnt_d   = '0;
      inv_cnt_d   = '0;
      lives_d     = LIVES_INIT;
      score_d     = '0;
      dead_d      = 1'b0;
      jump_prev_d = 1'b0;
      jump_req_d  = 1'b0;
    end else if (tick && !dead_q) begin
      if (vert_q == V_GROUND) begin
        if (req_now) begin
          vert_d     = V_AIR;
          air_cnt_d  = AIR_INIT;
          jump_req_d = 1'b0;
        end
      end else if (air_cnt_q == '0) begin
        vert_d = V_GROUND;
      end else begin
        air_cnt_d = air_cnt_q - AW'(1);
      end

      // Collision uses the height the player has after this tick's move.
      air_now   = (vert_d == V_AIR);
      hit_now   = (is_low & ~air_now) | (is_high & air_now);
      clear_now = (is_low | is_high) & ~hit_now;

      case (health_q)
        H_ALIVE: begin
          if (hit_now) begin
            lives_d = lives_q - LW'(1);
            hit_d   = 1'b1;
            if (lives_q == LW'(1)) begin
              health_d = H_DEAD;
              dead_d   = 1'b1;
            end else if (INVULN_TICKS > 0) begin
              health_d  = H_INVULN;
              inv_cnt_d = INV_INIT;
            end
          end else if (clear_now) begin
            score_d  = sat_add(score_q, SCORE_W'(1));
            spulse_d = 1'b1;
          end
          if (is_bonus) begin
            score_d  = sat_add(score_q, BONUS_INC);
            spulse_d = 1'b1;
          end
        end
        H_INVULN: begin
          if (is_bonus) begin
            score_d  = sat_add(score_q, BONUS_INC);
            spulse_d = 1'b1;
          end
          if (inv_cnt_q == '0) health_d = H_ALIVE;
          else                 inv_cnt_d = inv_cnt_q - IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vert_q      <= V_GROUND;
      health_q    <= H_ALIVE;
      air_cnt_q   <= '0;
      inv_cnt_q   <= '0;
      lives_q     <= LIVES_INIT;
      score_q     <= '0;
      jump_prev_q <= 1'b0;
      jump_req_q  <= 1'b0;
      dead_q      <= 1'b0;
      hit_q       <= 1'b0;
      spulse_q    <= 1'b0;
    end else begin
      vert_q      <= vert_d;
      health_q    <= health_d;
      air_cnt_q   <= air_cnt_d;
      inv_cnt_q   <= inv_cnt_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      jump_prev_q <= jump_prev_d;
      jump_req_q  <= jump_req_d;
      dead_q      <= dead_d;
      hit_q       <= hit_d;
      spulse_q    <= spulse_d;
    end
  end

  assign is_dead     = dead_q;
  assign airborne    = (vert_q == V_AIR);
  assign lives       = lives_q;
  assign score       = score_q;
  assign hit_pulse   = hit_q;
  assign score_pulse = spulse_q;
endmodule

// File: tb/tb_runner_physics_core.sv
// Directed, table-driven bench for runner_physics_core (default and 4-bit score builds).
module tb_runner_physics_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        jump = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] map_tiles = '0;

  logic        is_dead, airborne, hit_pulse, score_pulse;
  logic [1:0]  lives;
  logic [15:0] score;
  logic        s_is_dead, s_airborne, s_hit_pulse, s_score_pulse;
  logic [1:0]  s_lives;
  logic [3:0]  s_score;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] E = 2'd0, L = 2'd1, H = 2'd2, B = 2'd3;

  runner_physics_core dut (
    .clk(clk), .rst(rst), .tick(tick), .map_tiles(map_tiles), .jump(jump),
    .restart(restart), .is_dead(is_dead), .airborne(airborne), .lives(lives),
    .score(score), .hit_pulse(hit_pulse), .score_pulse(score_pulse)
  );

  runner_physics_core #(.SCORE_W(4)) dut_s (
    .clk(clk), .rst(rst), .tick(tick), .map_tiles(map_tiles), .jump(jump),
    .restart(restart), .is_dead(s_is_dead), .airborne(s_airborne), .lives(s_lives),
    .score(s_score), .hit_pulse(s_hit_pulse), .score_pulse(s_score_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tk, jp, rs;
    logic [1:0] tile;
    logic       air;
    int         lv, sc;
    logic       dead, hit, sp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle; non-player tiles get random filler that must be ignored.
  task automatic step(input logic tk, input logic jp, input logic rs, input logic [1:0] code);
    tick      = tk;
    jump      = jp;
    restart   = rs;
    map_tiles = {code, 14'($urandom_range(0, 16383))};
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic tk, jp, rs, input logic [1:0] tile,
                     input logic air, input int lv, sc, input logic dead, hit, sp);
    vec_t v;
    v = '{tk, jp, rs, tile, air, lv, sc, dead, hit, sp};
    vq.push_back(v);
  endtask

  int s_exp, m_exp;

  initial begin
    // Jump arc, hits with invulnerability, game over, restart-with-tick.
    add(1,1,0,L, 1,3,1,0,0,1);
    add(0,0,0,E, 1,3,1,0,0,0);
    add(1,1,0,E, 1,3,1,0,0,0);
    add(1,0,0,E, 1,3,1,0,0,0);
    add(1,0,0,E, 0,3,1,0,0,0);
    add(1,0,0,E, 0,3,1,0,0,0);
    add(1,0,0,L, 0,2,1,0,1,0);
    for (int i = 0; i < 4; i++) add(1,0,0,L, 0,2,1,0,0,0);
    add(1,0,0,L, 0,1,1,0,1,0);
    add(0,0,0,E, 0,1,1,0,0,0);
    for (int i = 0; i < 4; i++) add(1,0,0,E, 0,1,1,0,0,0);
    add(1,0,0,H, 0,1,2,0,0,1);
    add(1,1,0,H, 1,0,2,1,1,0);
    add(1,0,0,L, 1,0,2,1,0,0);
    add(1,1,0,E, 1,0,2,1,0,0);
    add(1,0,1,L, 0,3,0,0,0,0);
    add(1,0,0,L, 0,2,0,0,1,0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_airborne", int'(airborne), 0);
    chk("reset_lives", int'(lives), 3);
    chk("reset_score", int'(score), 0);
    chk("reset_dead", int'(is_dead), 0);
    chk("reset_pulses", int'({hit_pulse, score_pulse}), 0);

    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, E);
      chk($sformatf("idle%0d_state", i), int'({is_dead, airborne, lives}), 3);
      chk($sformatf("idle%0d_score", i), int'(score), 0);
      chk($sformatf("idle%0d_pulses", i), int'({hit_pulse, score_pulse}), 0);
    end

    foreach (vq[i]) begin
      step(vq[i].tk, vq[i].jp, vq[i].rs, vq[i].tile);
      chk($sformatf("v%0d_airborne", i), int'(airborne), int'(vq[i].air));
      chk($sformatf("v%0d_lives", i), int'(lives), vq[i].lv);
      chk($sformatf("v%0d_score", i), int'(score), vq[i].sc);
      chk($sformatf("v%0d_dead", i), int'(is_dead), int'(vq[i].dead));
      chk($sformatf("v%0d_hit", i), int'(hit_pulse), int'(vq[i].hit));
      chk($sformatf("v%0d_spulse", i), int'(score_pulse), int'(vq[i].sp));
    end

    // Saturation on the 4-bit score instance, plus bonus handling.
    step(0, 0, 1, E);
    chk("restart_s_score", int'(s_score), 0);
    for (int i = 0; i < 13; i++) step(1, 0, 0, H);
    chk("preload_s_score", int'(s_score), 13);
    chk("preload_score", int'(score), 13);
    step(1, 0, 0, B);
`ifdef PHYS_BONUS_EN
    s_exp = 15;
    m_exp = 18;
    chk("bonus_spulse", int'(s_score_pulse), 1);
`else
    s_exp = 13;
    m_exp = 13;
    chk("code3_spulse", int'(s_score_pulse), 0);
`endif
    chk("bonus_s_score", int'(s_score), s_exp);
    chk("bonus_score", int'(score), m_exp);
    chk("bonus_no_hit", int'({s_hit_pulse, s_lives}), 3);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, H);
      s_exp = (s_exp + 1 > 15) ? 15 : s_exp + 1;
      m_exp = m_exp + 1;
      chk($sformatf("sat%0d_s_score", i), int'(s_score), s_exp);
      chk($sformatf("sat%0d_score", i), int'(score), m_exp);
    end

    // Asynchronous reset in the middle of a jump.
    step(1, 1, 0, E);
    chk("prejump_airborne", int'(airborne), 1);
    tick = 1'b0;
    jump = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_airborne", int'(airborne), 0);
    chk("async_rst_score", int'(score), 0);
    chk("async_rst_lives", int'(lives), 3);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, E);
    chk("post_rst_airborne", int'(airborne), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
